lfsr_rng_arbiter: RTL and testbench

- Shares one 4-bit maximal-length LFSR random source between NREQ requesters.
- Round-robin arbitration; per grant, the LFSR steps STEPS times, then one word is delivered under a valid/ack handshake.
- Also owns reseeding of the LFSR.
- Sits between the LFSR datapath and its consumers (scramblers, test-pattern generators); no consumer drives the LFSR enable directly.

---
 rtl/lfsr_rng_arbiter_pkg.sv | 18 +
 rtl/lfsr_rng_arbiter_step_core.sv | 28 ++
 rtl/lfsr_rng_arbiter.sv | 133 +++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rng_arbiter_pkg.sv
// Shared types and constants for the LFSR random-source arbiter.
// The feedback taps describe x^4+x^3+1 for a right-shifting register.
package lfsr_rng_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam int          LFSR_W       = 4;
  localparam logic [3:0]  DEFAULT_SEED = 4'b0010;

  // New MSB is s[TAP_HI] ^ s[TAP_LO]; all other bits shift right by one.
  localparam int          TAP_HI       = 1;
  localparam int          TAP_LO       = 0;

endpackage

// File: rtl/lfsr_rng_arbiter_step_core.sv
// LFSR register with advance enable and synchronous load; load wins over advance.
// The owner guarantees load_val is never zero, so the register cannot lock up.
module lfsr_step_core
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= {q[TAP_HI] ^ q[TAP_LO], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin owner of a shared LFSR: grants one requester, steps the LFSR
// STEPS times, then holds the word under a valid/ack handshake.
module lfsr_rng_arbiter
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter int               NREQ  = 4,
  parameter int               WIDTH = LFSR_W,
  parameter int               STEPS = 1,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ack,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  output logic             seed_rej,
  output logic             busy
);

  localparam int PW = $clog2(NREQ);

  state_t          state, state_next;
  logic [PW-1:0]   ptr, ptr_next;
  logic [PW-1:0]   gnt_idx, idx_next;
  logic [3:0]      cnt, cnt_next;
  logic [NREQ-1:0] gnt_next;
  logic            valid_next, rej_next;
  logic            lfsr_en, lfsr_load;
  logic [WIDTH-1:0] load_val;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW:0]     k;

  assign load_val = (seed_val == '0) ? SEED : seed_val;

  lfsr_step_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (lfsr_en),
    .load     (lfsr_load),
    .load_val (load_val),
    .q        (rnd_data)
  );

  // Scan offsets from farthest to nearest so the requester right after ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    k          = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = {1'b0, ptr} + (PW+1)'(i);
      if (k >= (PW+1)'(NREQ)) k = k - (PW+1)'(NREQ);
      if (req[k[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = k[PW-1:0];
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    idx_next   = gnt_idx;
    ptr_next   = ptr;
    cnt_next   = cnt;
    valid_next = rnd_valid;
    rej_next   = 1'b0;
    lfsr_en    = 1'b0;
    lfsr_load  = 1'b0;
    case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (pick_found) begin
          gnt_next   = NREQ'(1) << pick_idx;
          idx_next   = pick_idx;
          cnt_next   = 4'(STEPS);
          state_next = STEP;
        end
      end
      STEP: begin
        lfsr_en  = 1'b1;
        cnt_next = cnt - 4'd1;
        rej_next = seed_load;
        if (cnt == 4'd1) begin
          state_next = DELIVER;
          valid_next = 1'b1;
        end
      end
      DELIVER: begin
        rej_next = seed_load;
        if (rnd_valid && rnd_ack) begin
          gnt_next   = '0;
          valid_next = 1'b0;
          ptr_next   = gnt_idx;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      ptr       <= PW'(NREQ - 1);
      cnt       <= '0;
      rnd_valid <= 1'b0;
      seed_rej  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      gnt       <= gnt_next;
      gnt_idx   <= idx_next;
      ptr       <= ptr_next;
      cnt       <= cnt_next;
      rnd_valid <= valid_next;
      seed_rej  <= rej_next;
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench: one arbiter with STEPS=1 for the main sequence and one with
// STEPS=3 for the reset-during-STEP case; expected words are hand-derived.
module tb_lfsr_rng_arbiter;

  logic       clk = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  logic       rst1, ack1, sl1, valid1, rej1, busy1;
  logic [3:0] req1, sv1, gnt1, data1;
  logic       rst3, ack3, sl3, valid3, rej3, busy3;
  logic [3:0] req3, sv3, gnt3, data3;

  // Full LFSR orbit starting after 0010; the last entry closes the period.
  logic [3:0] seq [15] = '{4'b1001, 4'b1100, 4'b0110, 4'b1011, 4'b0101,
                           4'b1010, 4'b1101, 4'b1110, 4'b1111, 4'b0111,
                           4'b0011, 4'b0001, 4'b1000, 4'b0100, 4'b0010};

  always #5 clk = ~clk;

  lfsr_rng_arbiter #(.NREQ(4), .WIDTH(4), .STEPS(1), .SEED(4'b0010)) u_dut1 (
    .clk(clk), .rst(rst1), .req(req1), .gnt(gnt1), .rnd_data(data1),
    .rnd_valid(valid1), .rnd_ack(ack1), .seed_load(sl1), .seed_val(sv1),
    .seed_rej(rej1), .busy(busy1)
  );

  lfsr_rng_arbiter #(.NREQ(4), .WIDTH(4), .STEPS(3), .SEED(4'b0010)) u_dut3 (
    .clk(clk), .rst(rst3), .req(req3), .gnt(gnt3), .rnd_data(data3),
    .rnd_valid(valid3), .rnd_ack(ack3), .seed_load(sl3), .seed_val(sv3),
    .seed_rej(rej3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete grant on the STEPS=1 instance with an immediate ack.
  task automatic serve1(input logic [3:0] r, input logic [3:0] eg, input logic [3:0] ew,
                        input string tag);
    int n;
    req1 = r;
    tick();
    check({tag, "_gnt"}, gnt1, eg);
    check({tag, "_busy"}, busy1, 1);
    n = 0;
    while (valid1 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 1);
    check({tag, "_word"}, data1, ew);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    req1 = '0;
    check({tag, "_rel_gnt"}, gnt1, 4'b0000);
    check({tag, "_rel_valid"}, valid1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst1 = 1'b0; req1 = '0; ack1 = 1'b0; sl1 = 1'b0; sv1 = '0;
    rst3 = 1'b0; req3 = '0; ack3 = 1'b0; sl3 = 1'b0; sv3 = '0;
    tick();
    tick();
    check("rst_gnt", gnt1, 4'b0000);
    check("rst_valid", valid1, 0);
    check("rst_rej", rej1, 0);
    check("rst_busy", busy1, 0);
    check("rst_data", data1, 4'b0010);
    rst1 = 1'b1;
    rst3 = 1'b1;

    // Single requester, three successive words.
    serve1(4'b0001, 4'b0001, 4'b1001, "single0");
    serve1(4'b0001, 4'b0001, 4'b1100, "single1");
    serve1(4'b0001, 4'b0001, 4'b0110, "single2");

    // Fresh reset, then all four requesting: round-robin order from req[0].
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    serve1(4'b1111, 4'b0001, 4'b1001, "rr0");
    serve1(4'b1111, 4'b0010, 4'b1100, "rr1");
    serve1(4'b1111, 4'b0100, 4'b0110, "rr2");
    serve1(4'b1111, 4'b1000, 4'b1011, "rr3");
    serve1(4'b1111, 4'b0001, 4'b0101, "rr4");

    // Reseed from IDLE: zero seed substitutes 0010, 1111 loads as given.
    sl1 = 1'b1; sv1 = 4'b0000;
    tick();
    sl1 = 1'b0;
    check("seed0_data", data1, 4'b0010);
    check("seed0_gnt", gnt1, 4'b0000);
    serve1(4'b0001, 4'b0001, 4'b1001, "seed0_word");
    sl1 = 1'b1; sv1 = 4'b1111;
    tick();
    sl1 = 1'b0;
    check("seedF_data", data1, 4'b1111);
    serve1(4'b0001, 4'b0001, 4'b0111, "seedF_word");

    // Reseed attempt during DELIVER is rejected for one cycle.
    req1 = 4'b0001;
    tick();
    check("rej_gnt", gnt1, 4'b0001);
    tick();
    check("rej_valid", valid1, 1);
    check("rej_word", data1, 4'b0011);
    sl1 = 1'b1; sv1 = 4'b0101;
    tick();
    sl1 = 1'b0;
    check("rej_pulse", rej1, 1);
    check("rej_word_held", data1, 4'b0011);
    check("rej_valid_held", valid1, 1);
    tick();
    check("rej_pulse_end", rej1, 0);
    check("rej_word_held2", data1, 4'b0011);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    req1 = '0;
    check("rej_release", valid1, 0);

    // Seed and request together in IDLE: seed first, grant one cycle later.
    sl1 = 1'b1; sv1 = 4'b1000; req1 = 4'b0010;
    tick();
    sl1 = 1'b0;
    check("both_gnt0", gnt1, 4'b0000);
    check("both_busy0", busy1, 0);
    check("both_data", data1, 4'b1000);
    tick();
    check("both_gnt1", gnt1, 4'b0010);
    tick();
    check("both_valid", valid1, 1);
    check("both_word", data1, 4'b0100);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    req1 = '0;

    // Request dropped after grant, ack delayed five cycles.
    req1 = 4'b0100;
    tick();
    check("drop_gnt", gnt1, 4'b0100);
    req1 = '0;
    tick();
    check("drop_valid", valid1, 1);
    check("drop_word", data1, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d_gnt", i), gnt1, 4'b0100);
      check($sformatf("hold%0d_valid", i), valid1, 1);
      check($sformatf("hold%0d_word", i), data1, 4'b0010);
    end
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("drop_rel_gnt", gnt1, 4'b0000);
    check("drop_rel_valid", valid1, 0);

    // Stray ack in IDLE is ignored.
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("stray_busy", busy1, 0);
    check("stray_data", data1, 4'b0010);

    // Fifteen grants walk the full orbit and land back on 0010.
    for (int i = 0; i < 15; i++) begin
      serve1(4'b0001, 4'b0001, seq[i], $sformatf("period%0d", i));
      check($sformatf("nonzero%0d", i), (data1 == 4'b0000), 0);
    end

    // STEPS=3 instance: reset in the middle of STEP.
    req3 = 4'b0001;
    tick();
    check("s3_gnt", gnt3, 4'b0001);
    tick();
    check("s3_busy", busy3, 1);
    check("s3_step_data", data3, 4'b1001);
    rst3 = 1'b0;
    #1;
    check("s3_rst_gnt", gnt3, 4'b0000);
    check("s3_rst_valid", valid3, 0);
    check("s3_rst_data", data3, 4'b0010);
    check("s3_rst_busy", busy3, 0);
    req3 = '0;
    tick();
    rst3 = 1'b1;
    req3 = 4'b0100;
    tick();
    check("s3_regnt", gnt3, 4'b0100);
    n = 0;
    while (valid3 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("s3_lat", n, 3);
    check("s3_word", data3, 4'b0110);
    ack3 = 1'b1;
    tick();
    ack3 = 1'b0;
    req3 = '0;
    check("s3_rel_valid", valid3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
